op_sequencer: RTL
=================

# op_sequencer

Command front-end for the calculator breadboard. Buffers (opcode, operand) commands from a host in a small FIFO and issues one per clock onto the breadboard's `OP`/`IN` inputs. It watches the datapath `ERR` bits and halts issue on an opcode-relevant error until the host clears it. It sits directly upstream of the breadboard; the breadboard's accumulator consumes each issued command on the following `CLK` edge.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `W`, 16: operand width; must match breadboard `IN`.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `CMD_VALID`  in  1  host offers a command.
- `CMD_READY`  out  1  FIFO can accept a command.
- `CMD_OP`  in  4  opcode to enqueue.
- `CMD_IN`  in  W  operand to enqueue.
- `CLR`  in  1  clears HALT; ignored outside HALT.
- `ERR`  in  2  breadboard error bits: [0] overflow, [1] divide/mod by zero.
- `OP`  out  4  registered opcode to the breadboard.
- `IN`  out  W  registered operand to the breadboard.
- `BUSY`  out  1  FIFO non-empty or a command is currently presented.
- `HALT`  out  1  issue stopped on error.
- `ERR_LATCH`  out  2  masked error that caused HALT.
- `ISSUED`  out  8  count of commands popped; wraps.

## Operation
- Push: on an edge with `CMD_VALID && CMD_READY`, the FIFO writes (`CMD_OP`, `CMD_IN`). `CMD_READY = (count != DEPTH)` from registered count, and 0 while `RST_N` is low. There is no push-on-full even if a pop occurs on the same edge.
- States: IDLE (nothing presented), ISSUE (a command is on `OP`/`IN`, `CUR_VALID=1`), HALT.
- IDLE/ISSUE, each edge:
  - If the presented command errs (see error mask), go to HALT.
  - Else, if the FIFO is non-empty: pop the head onto `OP`/`IN`, increment `ISSUED`, go to ISSUE.
  - Else: `OP<=0000`, `IN<=0`, go to IDLE.
- Error mask, evaluated only when `CUR_VALID=1`, at the edge ending the command's presentation cycle:
  - `ERR[0]` counts only for `OP` 0010/0011.
  - `ERR[1]` counts only for `OP` 0101/0110.
  - All other opcodes ignore `ERR`.
- On error:
  - `HALT<=1` and `ERR_LATCH<=`masked `ERR`.
  - `OP<=0000`, `IN<=0`, no pop.
  - The accumulator has already captured the erroneous result; this block does not undo it.
- HALT:
  - Pushes are still accepted while the FIFO is not full.
  - `OP`/`IN` stay at no-op/0.
  - `CLR` high at an edge sets `HALT<=0`, `ERR_LATCH<=00` and goes to IDLE; the next edge resumes popping.
- Error detection beats `CLR` on the same edge. `CLR` is not evaluated outside HALT.
- `ISSUED` wraps from 255 to 0.
- Simultaneous push and pop with FIFO non-full: both occur and count is unchanged.
- Push into an empty FIFO has no bypass: the entry is written at edge k, presented after edge k+1, and consumed by the accumulator at edge k+2.

## Timing
- Reset (`RST_N` low, asynchronous, immediate):
  - FIFO emptied; state IDLE.
  - `OP=0000`, `IN=0`, `HALT=0`, `ERR_LATCH=00`, `ISSUED=0`, `BUSY=0`, `CMD_READY=0`.
- After reset release, `CMD_READY=1` combinationally; the first push can land on the first rising edge.
- Throughput: one command per cycle sustained.
- Push-to-present latency: 2 edges. Present-to-consume latency: 1 edge.
- `ERR` is sampled on the same edge the accumulator captures. `ERR` must be settled a setup time before that edge, since it is combinational in the breadboard.
- `HALT` asserts on that same edge. The command queued behind the erroring one is not issued.
- `BUSY` and `CMD_READY` are combinational from registered state only; there are no combinational paths from inputs to them.
- Reset mid-stream drops all queued commands. Reset mid-HALT clears HALT.

## Test plan
- Reset, then push (1111,0), (0010,5), (0010,7) back-to-back:
  - `OP` shows 1111, 0010, 0010 on consecutive cycles starting 2 edges after the first push.
  - Breadboard `OUT=12`; `ISSUED=3`; `BUSY` falls 1 cycle after the last presentation.
- Push (0101,0) with accumulator at 9, then push (0010,1):
  - `HALT=1` and `ERR_LATCH=10` on the edge ending the div cycle.
  - `OP` held at 0000, FIFO keeps 1 entry, `ISSUED=1`.
  - Pulse `CLR`: (0010,1) issues 2 edges later.
- Push (0010,0) while `ERR[1]=1` from the datapath: no HALT (masked), `ISSUED` increments.
- Force `ERR=01` during a 0011 command while `CLR=1` on the same edge: HALT wins, `ERR_LATCH=01`.
- While in HALT, push 5 commands: `CMD_READY` drops after the 4th, the 5th is held. Clear HALT: `READY` returns 1 edge after the first pop.
- Drop `RST_N` between edges mid-stream: outputs go to reset values immediately, and after release `ISSUED=0`, `BUSY=0`.
- 256 pushes of (0000,0): `ISSUED` wraps to 0.

Source files
------------

// File: rtl/op_sequencer.sv
// op_sequencer: FIFO-buffered command issuer for the calculator breadboard with error halt
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY      host handshake; CMD_OP/CMD_IN are the enqueued command
//   CLR                      clears HALT (only evaluated while halted)
//   ERR                      breadboard error bits: [0] overflow, [1] divide/mod by zero
//   OP, IN                   registered command presented to the breadboard
//   BUSY                     FIFO non-empty or a command is presented
//   HALT, ERR_LATCH          halted flag and the masked error that caused it
//   ISSUED                   wrapping count of popped commands
module op_sequencer #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CMD_VALID,
  output logic         CMD_READY,
  input  logic [3:0]   CMD_OP,
  input  logic [W-1:0] CMD_IN,
  input  logic         CLR,
  input  logic [1:0]   ERR,
  output logic [3:0]   OP,
  output logic [W-1:0] IN,
  output logic         BUSY,
  output logic         HALT,
  output logic [1:0]   ERR_LATCH,
  output logic [7:0]   ISSUED
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, HALTED} state_t;
  state_t state, state_nx;
  logic [3:0] op_mem [DEPTH];
  logic [W-1:0] in_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop;
  logic [1:0] err_m, latch_nx;
  logic [3:0] op_nx;
  logic [W-1:0] in_nx;
  // Gated by RST_N so the host sees not-ready throughout reset.
  assign CMD_READY = RST_N && (count != (AW+1)'(DEPTH));
  assign push = CMD_VALID && CMD_READY;
  assign BUSY = (count != '0) || (state == ISSUE);
  assign HALT = (state == HALTED);
  // Each error bit only matters for the opcodes that can raise it.
  assign err_m = (state == ISSUE) ? {ERR[1] & (OP == 4'b0101 || OP == 4'b0110),
                                     ERR[0] & (OP == 4'b0010 || OP == 4'b0011)} : 2'b00;
  always_comb begin
    state_nx = state;
    op_nx = OP;
    in_nx = IN;
    latch_nx = ERR_LATCH;
    pop = 1'b0;
    if (state == HALTED) begin
      if (CLR) begin
        state_nx = IDLE;
        latch_nx = 2'b00;
      end
    end else if (err_m != 2'b00) begin
      state_nx = HALTED;
      latch_nx = err_m;
      op_nx = 4'b0000;
      in_nx = '0;
    end else if (count != '0) begin
      pop = 1'b1;
      op_nx = op_mem[rd_ptr];
      in_nx = in_mem[rd_ptr];
      state_nx = ISSUE;
    end else begin
      op_nx = 4'b0000;
      in_nx = '0;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      OP <= 4'b0000;
      IN <= '0;
      ERR_LATCH <= 2'b00;
      ISSUED <= 8'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      OP <= op_nx;
      IN <= in_nx;
      ERR_LATCH <= latch_nx;
      ISSUED <= ISSUED + 8'(pop);
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      op_mem[wr_ptr] <= CMD_OP;
      in_mem[wr_ptr] <= CMD_IN;
    end
  end
endmodule
